// File: rtl/mutex_req_ctrl.sv
// mutex_req_ctrl
//
// Synchronous requester front end for a two-input asynchronous mutex.
// Each of two local clients raises a level request. The block turns it into a
// four-phase r/g handshake toward the mutex, brings the returned grant into the
// clock domain through a two-flop synchronizer, and tracks ownership per channel.
// An optional hold timer forces release after HOLD_MAX owned cycles. Grant-line
// protocol violations raise a sticky error flag.
//
// Parameters
//   CW        width of the per-channel hold counters
//   HOLD_MAX  maximum owned cycles per grant (0 disables forced release)
//
// Ports
//   clk              system clock, all state on posedge
//   reset            synchronous active-high reset, clears all state
//   req1, req2       client level requests
//   rel1, rel2       single-cycle client release pulses (only honoured in OWN)
//   r1, r2           requests to the mutex (decoded from registered state)
//   g1, g2           asynchronous mutex grants
//   owned1, owned2   high while the channel owns the resource
//   forced1, forced2 one-cycle pulse in the last owned cycle of a timer release
//   proto_err        sticky grant-protocol violation flag
module mutex_req_ctrl #(
  parameter int unsigned     CW       = 8,
  parameter logic [CW-1:0]   HOLD_MAX = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic req2,
  input  logic rel1,
  input  logic rel2,
  output logic r1,
  output logic r2,
  input  logic g1,
  input  logic g2,
  output logic owned1,
  output logic owned2,
  output logic forced1,
  output logic forced2,
  output logic proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OWN  = 2'd2,
    RET  = 2'd3
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = HOLD_MAX - CW'(1);
  localparam bit            HOLD_EN   = (HOLD_MAX != '0);

  logic [1:0] req_v;
  logic [1:0] rel_v;
  logic [1:0] g_v;

  assign req_v = {req2, req1};
  assign rel_v = {rel2, rel1};
  assign g_v   = {g2, g1};

  state_t        state_q    [2];
  state_t        state_d    [2];
  logic [CW-1:0] hold_cnt_q [2];
  logic [CW-1:0] hold_cnt_d [2];
  // Request withdrawn while waiting for the grant: finish the handshake via RET.
  logic [1:0]    drop_q;
  logic [1:0]    drop_d;
  logic [1:0]    sync_q;
  logic [1:0]    sync_d;
  logic [1:0]    gs_q;
  logic [1:0]    gs_d;
  logic          proto_err_q;
  logic          proto_err_d;

  logic [1:0]    r_v;
  logic [1:0]    owned_v;
  logic [1:0]    forced_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= IDLE;
        hold_cnt_q[i] <= '0;
      end
      drop_q      <= '0;
      sync_q      <= '0;
      gs_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]    <= state_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
      drop_q      <= drop_d;
      sync_q      <= sync_d;
      gs_q        <= gs_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    sync_d      = g_v;
    gs_d        = sync_q;
    // Both synchronized grants high at once means mutex exclusion is broken.
    proto_err_d = proto_err_q | (&gs_q);
    drop_d      = '0;
    r_v         = '0;
    owned_v     = '0;
    forced_v    = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i]    = state_q[i];
      hold_cnt_d[i] = '0;
      case (state_q[i])
        IDLE: begin
          // A grant with no request outstanding is a protocol fault; do not
          // start a new handshake on top of it.
          if (gs_q[i]) begin
            proto_err_d = 1'b1;
          end else if (req_v[i]) begin
            state_d[i] = REQ;
          end
        end
        REQ: begin
          r_v[i] = 1'b1;
          if (gs_q[i]) begin
            state_d[i] = (drop_q[i] || !req_v[i]) ? RET : OWN;
          end else begin
            drop_d[i] = drop_q[i] | ~req_v[i];
          end
        end
        OWN: begin
          r_v[i]        = 1'b1;
          owned_v[i]    = 1'b1;
          hold_cnt_d[i] = hold_cnt_q[i] + CW'(1);
          if (!gs_q[i]) begin
            // Grant vanished under us: flag it and still return to zero.
            proto_err_d = 1'b1;
            state_d[i]  = RET;
          end else if (rel_v[i] || !req_v[i]) begin
            // Client release wins over a coincident timer expiry.
            state_d[i] = RET;
          end else if (HOLD_EN && (hold_cnt_q[i] == HOLD_LAST)) begin
            state_d[i]  = RET;
            forced_v[i] = 1'b1;
          end
        end
        RET: begin
          if (!gs_q[i]) begin
            state_d[i] = IDLE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  assign r1        = r_v[0];
  assign r2        = r_v[1];
  assign owned1    = owned_v[0];
  assign owned2    = owned_v[1];
  assign forced1   = forced_v[0];
  assign forced2   = forced_v[1];
  assign proto_err = proto_err_q;

endmodule
